// File: rtl/cmn_bin2onehot_tracker_pkg.sv
// Purpose: shared types for the binary-to-onehot entry tracker.
// Latency: n/a (types only).
// Backpressure: n/a.
package cmn_bin2onehot_tracker_pkg;

  // One-cycle error pulses raised by the tracker, one bit per error class.
  typedef struct packed {
    logic dbl_set;   // set hit an entry that was already valid
    logic clr_idle;  // clear hit an entry that was not valid
    logic rng;       // a set or clear index was outside the table
  } err_t;

  localparam err_t ERR_NONE = '0;

endpackage

// File: rtl/cmn_bin2onehot.sv
// Purpose: combinational binary index to onehot decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; indices >= ONEHOT_WIDTH decode to all-zero.
module cmn_bin2onehot
  import cmn_bin2onehot_tracker_pkg::*;
#(
  parameter int ONEHOT_WIDTH = 8,
  localparam int IDX_WIDTH = (ONEHOT_WIDTH > 1) ? $clog2(ONEHOT_WIDTH) : 1
) (
  input  logic [IDX_WIDTH-1:0]    idx,
  output logic [ONEHOT_WIDTH-1:0] onehot
);

  // Each output bit compares against its own position, so an index with no
  // matching position (out of range) leaves every bit low.
  for (genvar g = 0; g < ONEHOT_WIDTH; g++) begin : g_dec
    assign onehot[g] = (idx == IDX_WIDTH'(g));
  end

endmodule

// File: rtl/cmn_bin2onehot_tracker.sv
// Purpose: per-entry valid tracker driven by binary set/clear indices.
// Latency: 1 cycle from set/clear request to entry_vld/cnt/error update.
// Backpressure: set_rdy low while full; clear is always accepted.
module cmn_bin2onehot_tracker
  import cmn_bin2onehot_tracker_pkg::*;
#(
  parameter int ENTRY_NUM = 8,
  localparam int BIN_WIDTH = $clog2(ENTRY_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_vld,
  input  logic [BIN_WIDTH-1:0] set_idx,
  output logic                 set_rdy,
  input  logic                 clr_vld,
  input  logic [BIN_WIDTH-1:0] clr_idx,
  output logic [ENTRY_NUM-1:0] entry_vld,
  output logic [ENTRY_NUM-1:0] set_onehot,
  output logic                 set_onehot_vld,
  output logic [BIN_WIDTH:0]   cnt,
  output logic                 full,
  output logic                 empty,
  output logic [BIN_WIDTH-1:0] free_idx,
  output logic                 err_dbl_set,
  output logic                 err_clr_idle,
  output logic                 err_range
);

  localparam logic [BIN_WIDTH:0] ENTRY_NUM_C = (BIN_WIDTH+1)'(ENTRY_NUM);

  logic [ENTRY_NUM-1:0] set_dec;
  logic [ENTRY_NUM-1:0] clr_dec;
  logic [ENTRY_NUM-1:0] set_req_vec;
  logic [ENTRY_NUM-1:0] clr_eff_vec;
  logic [ENTRY_NUM-1:0] set_eff_vec;
  logic [ENTRY_NUM-1:0] vld_nxt;
  logic [BIN_WIDTH:0]   cnt_nxt;
  logic                 set_fire;
  logic                 set_in_rng;
  logic                 clr_in_rng;
  logic                 set_any;
  logic                 clr_any;
  err_t                 err_nxt;
  err_t                 err_q;

  cmn_bin2onehot #(.ONEHOT_WIDTH(ENTRY_NUM)) u_set_dec (
    .idx    (set_idx),
    .onehot (set_dec)
  );

  cmn_bin2onehot #(.ONEHOT_WIDTH(ENTRY_NUM)) u_clr_dec (
    .idx    (clr_idx),
    .onehot (clr_dec)
  );

  assign full     = (cnt == ENTRY_NUM_C);
  assign empty    = (cnt == '0);
  assign set_rdy  = ~full;
  assign set_fire = set_vld && set_rdy;

  assign set_in_rng = ({1'b0, set_idx} < ENTRY_NUM_C);
  assign clr_in_rng = ({1'b0, clr_idx} < ENTRY_NUM_C);

  // Work out which set/clear actually changes state: the clear looks at the
  // old vector, and a set may land on an entry that the same-cycle clear frees,
  // so a same-index set+clear leaves the entry valid with no net count change.
  always_comb begin
    set_req_vec = set_fire ? set_dec : '0;
    clr_eff_vec = clr_vld ? (clr_dec & entry_vld) : '0;
    set_eff_vec = set_req_vec & (~entry_vld | clr_eff_vec);
    vld_nxt     = (entry_vld & ~clr_eff_vec) | set_eff_vec;
    set_any     = |set_eff_vec;
    clr_any     = |clr_eff_vec;
    cnt_nxt     = cnt + (BIN_WIDTH+1)'(set_any) - (BIN_WIDTH+1)'(clr_any);
  end

  // Classify ignored requests into the three error pulses.
  always_comb begin
    err_nxt          = ERR_NONE;
    err_nxt.dbl_set  = |(set_req_vec & entry_vld & ~clr_eff_vec);
    err_nxt.clr_idle = clr_vld && (|(clr_dec & ~entry_vld & ~set_req_vec));
    err_nxt.rng      = (set_fire && !set_in_rng) || (clr_vld && !clr_in_rng);
  end

  // Lowest-index free entry; all-ones when nothing is free.
  always_comb begin
    free_idx = '1;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!entry_vld[i]) free_idx = BIN_WIDTH'(i);
    end
  end

  // Register valid vector, count, last-set onehot and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_vld      <= '0;
      cnt            <= '0;
      set_onehot     <= '0;
      set_onehot_vld <= 1'b0;
      err_q          <= ERR_NONE;
    end else begin
      entry_vld      <= vld_nxt;
      cnt            <= cnt_nxt;
      set_onehot_vld <= set_any;
      if (set_any) set_onehot <= set_eff_vec;
      err_q          <= err_nxt;
    end
  end

  assign err_dbl_set  = err_q.dbl_set;
  assign err_clr_idle = err_q.clr_idle;
  assign err_range    = err_q.rng;

endmodule

// File: tb/tb_cmn_bin2onehot_tracker.sv
module tb_cmn_bin2onehot_tracker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ENTRY_NUM = 8 instance
  logic       a_set_vld = 0, a_clr_vld = 0;
  logic [2:0] a_set_idx = 0, a_clr_idx = 0;
  logic       a_set_rdy, a_ohv, a_full, a_empty, a_edbl, a_eidle, a_erng;
  logic [7:0] a_vld, a_oh;
  logic [3:0] a_cnt;
  logic [2:0] a_free;

  cmn_bin2onehot_tracker #(.ENTRY_NUM(8)) dut8 (
    .clk(clk), .rst(rst),
    .set_vld(a_set_vld), .set_idx(a_set_idx), .set_rdy(a_set_rdy),
    .clr_vld(a_clr_vld), .clr_idx(a_clr_idx),
    .entry_vld(a_vld), .set_onehot(a_oh), .set_onehot_vld(a_ohv),
    .cnt(a_cnt), .full(a_full), .empty(a_empty), .free_idx(a_free),
    .err_dbl_set(a_edbl), .err_clr_idle(a_eidle), .err_range(a_erng)
  );

  // ENTRY_NUM = 6 instance
  logic       b_set_vld = 0, b_clr_vld = 0;
  logic [2:0] b_set_idx = 0, b_clr_idx = 0;
  logic       b_set_rdy, b_ohv, b_full, b_empty, b_edbl, b_eidle, b_erng;
  logic [5:0] b_vld, b_oh;
  logic [3:0] b_cnt;
  logic [2:0] b_free;

  cmn_bin2onehot_tracker #(.ENTRY_NUM(6)) dut6 (
    .clk(clk), .rst(rst),
    .set_vld(b_set_vld), .set_idx(b_set_idx), .set_rdy(b_set_rdy),
    .clr_vld(b_clr_vld), .clr_idx(b_clr_idx),
    .entry_vld(b_vld), .set_onehot(b_oh), .set_onehot_vld(b_ohv),
    .cnt(b_cnt), .full(b_full), .empty(b_empty), .free_idx(b_free),
    .err_dbl_set(b_edbl), .err_clr_idle(b_eidle), .err_range(b_erng)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_set_vld = 0; a_clr_vld = 0; b_set_vld = 0; b_clr_vld = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    // Requests presented during reset are discarded.
    rst = 1; a_set_vld = 1; a_set_idx = 3; a_clr_vld = 1; a_clr_idx = 1;
    tick();
    rst = 0; idle_all();
    n_checks++; if (a_vld !== 8'h00) begin n_fail++; $display("FAIL reset_entry_vld got %h exp %h", a_vld, 8'h00); end
    n_checks++; if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", a_cnt); end
    n_checks++; if ({a_empty, a_full, a_set_rdy} !== 3'b101) begin n_fail++; $display("FAIL reset_flags got %b exp 101", {a_empty, a_full, a_set_rdy}); end
    n_checks++; if (a_free !== 3'd0) begin n_fail++; $display("FAIL reset_free_idx got %0d exp 0", a_free); end
    n_checks++; if ({a_oh, a_ohv} !== 9'h000) begin n_fail++; $display("FAIL reset_onehot got %h/%b exp 00/0", a_oh, a_ohv); end
    n_checks++; if ({a_edbl, a_eidle, a_erng} !== 3'b000) begin n_fail++; $display("FAIL reset_err got %b exp 000", {a_edbl, a_eidle, a_erng}); end
  endtask

  task automatic test_set_basic();
    a_set_vld = 1; a_set_idx = 3;
    tick();
    a_set_vld = 0;
    n_checks++; if (a_vld !== 8'h08) begin n_fail++; $display("FAIL set3_entry_vld got %h exp 08", a_vld); end
    n_checks++; if (a_cnt !== 4'd1) begin n_fail++; $display("FAIL set3_cnt got %0d exp 1", a_cnt); end
    n_checks++; if ({a_oh, a_ohv} !== {8'h08, 1'b1}) begin n_fail++; $display("FAIL set3_onehot got %h/%b exp 08/1", a_oh, a_ohv); end
    n_checks++; if (a_free !== 3'd0) begin n_fail++; $display("FAIL set3_free_idx got %0d exp 0", a_free); end
    n_checks++; if (a_empty !== 1'b0) begin n_fail++; $display("FAIL set3_empty got %b exp 0", a_empty); end
    tick();
    n_checks++; if ({a_oh, a_ohv} !== {8'h08, 1'b0}) begin n_fail++; $display("FAIL onehot_hold got %h/%b exp 08/0", a_oh, a_ohv); end
  endtask

  task automatic test_fill_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a_set_vld = 1; a_set_idx = 3'(i);
      tick();
    end
    a_set_vld = 0;
    n_checks++; if (a_vld !== 8'hFF) begin n_fail++; $display("FAIL fill_entry_vld got %h exp FF", a_vld); end
    n_checks++; if (a_cnt !== 4'd8) begin n_fail++; $display("FAIL fill_cnt got %0d exp 8", a_cnt); end
    n_checks++; if ({a_full, a_set_rdy} !== 2'b10) begin n_fail++; $display("FAIL fill_full_rdy got %b exp 10", {a_full, a_set_rdy}); end
    n_checks++; if (a_free !== 3'b111) begin n_fail++; $display("FAIL fill_free_idx got %0d exp 7", a_free); end
    n_checks++; if ({a_oh, a_ohv} !== {8'h80, 1'b1}) begin n_fail++; $display("FAIL fill_onehot got %h/%b exp 80/1", a_oh, a_ohv); end
    // Extra set while full: not accepted, no error.
    a_set_vld = 1; a_set_idx = 2;
    tick();
    a_set_vld = 0;
    n_checks++; if ({a_vld, a_cnt} !== {8'hFF, 4'd8}) begin n_fail++; $display("FAIL full_extra_state got %h/%0d exp FF/8", a_vld, a_cnt); end
    n_checks++; if ({a_edbl, a_eidle, a_erng, a_ohv} !== 4'b0000) begin n_fail++; $display("FAIL full_extra_err got %b exp 0000", {a_edbl, a_eidle, a_erng, a_ohv}); end
    a_clr_vld = 1; a_clr_idx = 5;
    tick();
    a_clr_vld = 0;
    n_checks++; if (a_vld !== 8'hDF) begin n_fail++; $display("FAIL clr5_entry_vld got %h exp DF", a_vld); end
    n_checks++; if (a_free !== 3'd5) begin n_fail++; $display("FAIL clr5_free_idx got %0d exp 5", a_free); end
    n_checks++; if ({a_full, a_set_rdy, a_cnt} !== {2'b01, 4'd7}) begin n_fail++; $display("FAIL clr5_full_rdy_cnt got %b/%0d exp 01/7", {a_full, a_set_rdy}, a_cnt); end
  endtask

  task automatic test_same_idx();
    do_reset();
    a_set_vld = 1; a_set_idx = 2;
    tick();
    a_clr_vld = 1; a_clr_idx = 2;
    tick();
    idle_all();
    n_checks++; if ({a_vld, a_cnt} !== {8'h04, 4'd1}) begin n_fail++; $display("FAIL same_idx_state got %h/%0d exp 04/1", a_vld, a_cnt); end
    n_checks++; if ({a_edbl, a_eidle, a_erng} !== 3'b000) begin n_fail++; $display("FAIL same_idx_err got %b exp 000", {a_edbl, a_eidle, a_erng}); end
  endtask

  task automatic test_back_to_back();
    // Entry 2 valid: set 5 while clearing 2 in the same cycle.
    a_set_vld = 1; a_set_idx = 5; a_clr_vld = 1; a_clr_idx = 2;
    tick();
    idle_all();
    n_checks++; if ({a_vld, a_cnt} !== {8'h20, 4'd1}) begin n_fail++; $display("FAIL diff_idx_state got %h/%0d exp 20/1", a_vld, a_cnt); end
    n_checks++; if ({a_oh, a_ohv} !== {8'h20, 1'b1}) begin n_fail++; $display("FAIL diff_idx_onehot got %h/%b exp 20/1", a_oh, a_ohv); end
    n_checks++; if (a_free !== 3'd0) begin n_fail++; $display("FAIL diff_idx_free got %0d exp 0", a_free); end
  endtask

  task automatic test_errors();
    do_reset();
    a_set_vld = 1; a_set_idx = 4;
    tick();
    tick();  // second set on valid entry 4
    a_set_vld = 0;
    n_checks++; if ({a_edbl, a_eidle, a_erng} !== 3'b100) begin n_fail++; $display("FAIL dbl_set_pulse got %b exp 100", {a_edbl, a_eidle, a_erng}); end
    n_checks++; if ({a_vld, a_cnt, a_ohv} !== {8'h10, 4'd1, 1'b0}) begin n_fail++; $display("FAIL dbl_set_state got %h/%0d/%b exp 10/1/0", a_vld, a_cnt, a_ohv); end
    tick();
    n_checks++; if (a_edbl !== 1'b0) begin n_fail++; $display("FAIL dbl_set_one_cycle got %b exp 0", a_edbl); end
    a_clr_vld = 1; a_clr_idx = 6;
    tick();
    a_clr_vld = 0;
    n_checks++; if ({a_edbl, a_eidle, a_erng} !== 3'b010) begin n_fail++; $display("FAIL clr_idle_pulse got %b exp 010", {a_edbl, a_eidle, a_erng}); end
    n_checks++; if ({a_vld, a_cnt} !== {8'h10, 4'd1}) begin n_fail++; $display("FAIL clr_idle_state got %h/%0d exp 10/1", a_vld, a_cnt); end
    tick();
    n_checks++; if (a_eidle !== 1'b0) begin n_fail++; $display("FAIL clr_idle_one_cycle got %b exp 0", a_eidle); end
  endtask

  task automatic test_range();
    do_reset();
    b_set_vld = 1; b_set_idx = 7;
    tick();
    b_set_vld = 0;
    n_checks++; if ({b_edbl, b_eidle, b_erng} !== 3'b001) begin n_fail++; $display("FAIL range_set_pulse got %b exp 001", {b_edbl, b_eidle, b_erng}); end
    n_checks++; if ({b_vld, b_cnt, b_ohv} !== {6'h00, 4'd0, 1'b0}) begin n_fail++; $display("FAIL range_set_state got %h/%0d/%b exp 00/0/0", b_vld, b_cnt, b_ohv); end
    b_clr_vld = 1; b_clr_idx = 6;
    tick();
    b_clr_vld = 0;
    n_checks++; if ({b_eidle, b_erng} !== 2'b01) begin n_fail++; $display("FAIL range_clr_pulse got %b exp 01", {b_eidle, b_erng}); end
    // Fill all six entries.
    for (int i = 0; i < 6; i++) begin
      b_set_vld = 1; b_set_idx = 3'(i);
      tick();
    end
    b_set_vld = 0;
    n_checks++; if ({b_vld, b_cnt, b_full, b_set_rdy} !== {6'h3F, 4'd6, 2'b10}) begin n_fail++; $display("FAIL fill6_state got %h/%0d/%b exp 3F/6/10", b_vld, b_cnt, {b_full, b_set_rdy}); end
    n_checks++; if (b_free !== 3'b111) begin n_fail++; $display("FAIL fill6_free_idx got %0d exp 7", b_free); end
    b_clr_vld = 1; b_clr_idx = 1;
    tick();
    b_clr_vld = 0;
    n_checks++; if ({b_vld, b_free, b_set_rdy} !== {6'h3D, 3'd1, 1'b1}) begin n_fail++; $display("FAIL clr1_6_state got %h/%0d/%b exp 3D/1/1", b_vld, b_free, b_set_rdy); end
  endtask

  task automatic test_reset_mid();
    b_set_vld = 1; b_set_idx = 1;
    rst = 1;
    tick();
    rst = 0; b_set_vld = 0;
    n_checks++; if ({b_vld, b_cnt} !== {6'h00, 4'd0}) begin n_fail++; $display("FAIL rst_mid_state got %h/%0d exp 00/0", b_vld, b_cnt); end
    n_checks++; if ({b_empty, b_full, b_set_rdy, b_free} !== {3'b101, 3'd0}) begin n_fail++; $display("FAIL rst_mid_flags got %b/%0d exp 101/0", {b_empty, b_full, b_set_rdy}, b_free); end
    n_checks++; if ({b_oh, b_ohv, b_edbl, b_eidle, b_erng} !== 10'h000) begin n_fail++; $display("FAIL rst_mid_oh_err got %h/%b exp 00/0000", b_oh, {b_ohv, b_edbl, b_eidle, b_erng}); end
  endtask

  initial begin
    #2;
    test_reset();
    test_set_basic();
    test_fill_full();
    test_same_idx();
    test_back_to_back();
    test_errors();
    test_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
